// File: rtl/wb_bot_poller.sv
// Wishbone classic master that polls the rojobot update flag, fetches BotInfo,
// acknowledges the interrupt and writes motor control. Optional macro: WB_POLLER_TIMEOUT_EN.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// S_IDLE    | engine stopped, bus quiet
// S_POLL_RD | read UPDT, bit0 says a new BotInfo is ready
// S_GAP     | POLL_GAP idle clocks between polls (also after any bus error)
// S_INFO_RD | read BOTINFO into bot_info
// S_ACK1    | write 1 to INTACK
// S_ACK0    | write 0 to INTACK (slave holds the level, so it must be cleared)
// S_CTRL_WR | write motctl_cmd to BOTCTRL
module wb_bot_poller #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned POLL_GAP  = 16,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        enable,
    input  logic [7:0]  motctl_cmd,
    input  logic        clr_err,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic [2:0]  wb_cti_o,
    output logic [1:0]  wb_bte_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    output logic [31:0] bot_info,
    output logic        info_valid,
    output logic        bus_err,
    output logic        busy
);

    localparam logic [31:0] ADR_BOTINFO = BASE_ADDR + 32'h0000_000C;
    localparam logic [31:0] ADR_BOTCTRL = BASE_ADDR + 32'h0000_0010;
    localparam logic [31:0] ADR_UPDT    = BASE_ADDR + 32'h0000_0014;
    localparam logic [31:0] ADR_INTACK  = BASE_ADDR + 32'h0000_0018;
    localparam logic [15:0] GAP_LOAD    = 16'(POLL_GAP - 1);

    if (POLL_GAP < 1 || POLL_GAP > 65535) begin : g_bad_poll_gap
        $error("wb_bot_poller: POLL_GAP must be 1..65535");
    end
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("wb_bot_poller: TIMEOUT must be 1..255");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_POLL_RD,
        S_GAP,
        S_INFO_RD,
        S_ACK1,
        S_ACK0,
        S_CTRL_WR
    } state_t;

    state_t      state;
    logic [15:0] gap_cnt;
    logic [31:0] tx_adr;
    logic [31:0] tx_dat;
    logic        tx_we;
    logic        tmo_hit;
    logic        xfer_err;

`ifdef WB_POLLER_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
    logic [7:0] tmo_cnt;
    assign tmo_hit = (tmo_cnt == TMO_LAST);
`else
    assign tmo_hit = 1'b0;
`endif

    assign wb_cti_o = 3'b000;
    assign wb_bte_o = 2'b00;

    // ack together with err counts as an error
    assign xfer_err = wb_err_i | tmo_hit;

    always_comb begin
        tx_adr = ADR_UPDT;
        tx_dat = 32'h0;
        tx_we  = 1'b0;
        case (state)
            S_INFO_RD: tx_adr = ADR_BOTINFO;
            S_ACK1: begin
                tx_adr = ADR_INTACK;
                tx_dat = 32'h1;
                tx_we  = 1'b1;
            end
            S_ACK0: begin
                tx_adr = ADR_INTACK;
                tx_we  = 1'b1;
            end
            S_CTRL_WR: begin
                tx_adr = ADR_BOTCTRL;
                tx_dat = {24'h0, motctl_cmd};
                tx_we  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= S_IDLE;
            gap_cnt    <= '0;
            wb_adr_o   <= '0;
            wb_dat_o   <= '0;
            wb_sel_o   <= '0;
            wb_we_o    <= 1'b0;
            wb_cyc_o   <= 1'b0;
            wb_stb_o   <= 1'b0;
            bot_info   <= '0;
            info_valid <= 1'b0;
            bus_err    <= 1'b0;
            busy       <= 1'b0;
`ifdef WB_POLLER_TIMEOUT_EN
            tmo_cnt    <= '0;
`endif
        end else begin
            info_valid <= 1'b0;
            // a new error later in this block overrides the clear
            if (clr_err) bus_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (enable) begin
                        state <= S_POLL_RD;
                        busy  <= 1'b1;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == '0) begin
                        state <= enable ? S_POLL_RD : S_IDLE;
                        busy  <= enable;
                    end else begin
                        gap_cnt <= gap_cnt - 16'd1;
                    end
                end
                default: begin
                    // bus states: entered with cyc=0, which gives the idle cycle between transfers
                    if (!wb_cyc_o) begin
                        wb_cyc_o <= 1'b1;
                        wb_stb_o <= 1'b1;
                        wb_sel_o <= 4'hF;
                        wb_adr_o <= tx_adr;
                        wb_dat_o <= tx_dat;
                        wb_we_o  <= tx_we;
`ifdef WB_POLLER_TIMEOUT_EN
                        tmo_cnt  <= '0;
`endif
                    end else if (xfer_err || wb_ack_i) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        wb_sel_o <= '0;
                        wb_we_o  <= 1'b0;
                        wb_adr_o <= '0;
                        wb_dat_o <= '0;
                        if (xfer_err) begin
                            bus_err <= 1'b1;
                            state   <= S_GAP;
                            gap_cnt <= GAP_LOAD;
                        end else begin
                            case (state)
                                S_POLL_RD: begin
                                    if (wb_dat_i[0]) begin
                                        state <= S_INFO_RD;
                                    end else begin
                                        state   <= S_GAP;
                                        gap_cnt <= GAP_LOAD;
                                    end
                                end
                                S_INFO_RD: begin
                                    bot_info   <= wb_dat_i;
                                    info_valid <= 1'b1;
                                    state      <= S_ACK1;
                                end
                                S_ACK1:  state <= S_ACK0;
                                S_ACK0:  state <= S_CTRL_WR;
                                default: begin
                                    state   <= S_GAP;
                                    gap_cnt <= GAP_LOAD;
                                end
                            endcase
                        end
                    end else begin
`ifdef WB_POLLER_TIMEOUT_EN
                        tmo_cnt <= tmo_cnt + 8'd1;
`endif
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_bot_poller.sv
// Directed bench for wb_bot_poller with a Wishbone responder model.
// Register block placed at 0xFFFF_FFF0 so offsets wrap past 2^32.
module tb_wb_bot_poller;

    localparam logic [31:0] A_UPDT   = 32'h0000_0004;
    localparam logic [31:0] A_INFO   = 32'hFFFF_FFFC;
    localparam logic [31:0] A_CTRL   = 32'h0000_0000;
    localparam logic [31:0] A_INTACK = 32'h0000_0008;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        enable = 1'b0;
    logic [7:0]  motctl_cmd = 8'h00;
    logic        clr_err = 1'b0;
    logic [31:0] wb_adr_o, wb_dat_o, bot_info;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o, wb_cyc_o, wb_stb_o, info_valid, bus_err, busy;
    logic [2:0]  wb_cti_o;
    logic [1:0]  wb_bte_o;
    logic [31:0] wb_dat_i = 32'h0;
    logic        wb_ack_i = 1'b0;
    logic        wb_err_i = 1'b0;

    wb_bot_poller #(.BASE_ADDR(32'hFFFF_FFF0), .POLL_GAP(16), .TIMEOUT(8)) dut (
        .clk(clk), .rstn(rstn), .enable(enable), .motctl_cmd(motctl_cmd), .clr_err(clr_err),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
        .bot_info(bot_info), .info_valid(info_valid), .bus_err(bus_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
        logic        err;
    } txn_t;

    txn_t        log_q[$];
    int          rises[$];
    int          cyc_n = 0;
    int          lat = 1;
    bit          never_ack = 1'b0;
    bit          err_en = 1'b0;
    logic [31:0] err_adr = 32'h0;
    bit          updt_val = 1'b0;
    logic [31:0] info_val = 32'h0;
    int          cnt = 0;
    int          stab_bad = 0;
    int          iv_cnt = 0;
    int          hi_cur = 0;
    int          last_hi = 0;
    bit          prev_cyc = 1'b0;
    txn_t        first;
    int          n_chk = 0;
    int          n_fail = 0;

    always @(posedge clk) cyc_n++;

    // responder: acks (or errs) after lat cycles of cyc, logs each completed transfer
    always @(negedge clk) begin
        txn_t t;
        if (wb_cyc_o && !prev_cyc) rises.push_back(cyc_n);
        if (wb_cyc_o) hi_cur++;
        else if (prev_cyc) begin
            last_hi = hi_cur;
            hi_cur  = 0;
        end
        prev_cyc = wb_cyc_o;
        if (info_valid) iv_cnt++;
        if (wb_cyc_o && wb_stb_o) begin
            t.adr = wb_adr_o; t.dat = wb_dat_o; t.sel = wb_sel_o; t.we = wb_we_o; t.err = 1'b0;
            if (cnt == 0) first = t;
            else if (t.adr !== first.adr || t.dat !== first.dat || t.sel !== first.sel || t.we !== first.we)
                stab_bad++;
            cnt++;
            if (!never_ack && !wb_ack_i && !wb_err_i && cnt >= lat) begin
                if (err_en && wb_adr_o == err_adr) begin
                    wb_err_i = 1'b1;
                    t.err = 1'b1;
                end else begin
                    wb_ack_i = 1'b1;
                    wb_dat_i = (wb_adr_o == A_UPDT) ? {31'h0, updt_val} :
                               (wb_adr_o == A_INFO) ? info_val : 32'hDEAD_BEEF;
                end
                log_q.push_back(t);
            end
        end else begin
            cnt = 0;
            wb_ack_i = 1'b0;
            wb_err_i = 1'b0;
            wb_dat_i = 32'h0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic txn_t get_txn(input int i);
        txn_t z;
        z.adr = 'x; z.dat = 'x; z.sel = 'x; z.we = 1'bx; z.err = 1'bx;
        if (i < log_q.size()) return log_q[i];
        return z;
    endfunction

    function automatic int spacing(input int i);
        if (i + 1 < rises.size()) return rises[i+1] - rises[i];
        return -1;
    endfunction

    task automatic wait_log(input int n, input int budget, input string tag);
        int k = 0;
        while (log_q.size() < n && k < budget) begin step(); k++; end
        chk(tag, 32'(log_q.size() >= n), 32'd1);
    endtask

    task automatic wait_rises(input int n, input int budget, input string tag);
        int k = 0;
        while (rises.size() < n && k < budget) begin step(); k++; end
        chk(tag, 32'(rises.size() >= n), 32'd1);
    endtask

    task automatic wait_cyc(input logic v, input int budget, input string tag);
        int k = 0;
        while (wb_cyc_o !== v && k < budget) begin step(); k++; end
        chk(tag, 32'(wb_cyc_o), 32'(v));
    endtask

    task automatic quiesce();
        wait_cyc(1'b0, 100, "quiesce_to");
        log_q.delete();
        rises.delete();
        stab_bad = 0;
        iv_cnt = 0;
    endtask

    initial begin
        txn_t t;
        // reset values
        repeat (3) step();
        chk("rst_cyc_stb", {wb_cyc_o, wb_stb_o, wb_we_o}, 32'd0);
        chk("rst_adr", wb_adr_o, 32'h0);
        chk("rst_dat", wb_dat_o, 32'h0);
        chk("rst_sel_cti_bte", {wb_sel_o, wb_cti_o, wb_bte_o}, 32'h0);
        chk("rst_bot_info", bot_info, 32'h0);
        chk("rst_flags", {info_valid, bus_err, busy}, 32'h0);

        // polling with UPDT=0, ack latency 1
        rstn = 1'b1;
        step();
        enable = 1'b1;
        lat = 1;
        wait_rises(3, 100, "poll_rises_to");
        chk("poll_space0", 32'(spacing(0)), 32'd18);
        chk("poll_space1", 32'(spacing(1)), 32'd18);
        t = get_txn(0);
        chk("poll_adr0", t.adr, A_UPDT);
        chk("poll_sel0", {28'h0, t.sel}, 32'hF);
        t = get_txn(1);
        chk("poll_adr1", t.adr, A_UPDT);
        begin
            int wr = 0;
            for (int i = 0; i < log_q.size(); i++) if (log_q[i].we) wr++;
            chk("poll_no_writes", 32'(wr), 32'd0);
        end
        chk("poll_busy", 32'(busy), 32'd1);

        // full update sequence
        quiesce();
        updt_val = 1'b1;
        info_val = 32'h3C50_0A04;
        motctl_cmd = 8'h33;
        wait_log(5, 100, "upd_log_to");
        updt_val = 1'b0;
        chk("upd_bot_info", bot_info, 32'h3C50_0A04);
        chk("upd_iv_cycles", 32'(iv_cnt), 32'd1);
        t = get_txn(0); chk("upd_t0_adr", t.adr, A_UPDT);
        t = get_txn(1); chk("upd_t1_adr", t.adr, A_INFO);
        chk("upd_t1_we", 32'(t.we), 32'd0);
        t = get_txn(2); chk("upd_t2_adr", t.adr, A_INTACK);
        chk("upd_t2_dat", t.dat, 32'h1);
        chk("upd_t2_we_sel", {27'h0, t.we, t.sel}, 32'h1F);
        t = get_txn(3); chk("upd_t3_adr", t.adr, A_INTACK);
        chk("upd_t3_dat", t.dat, 32'h0);
        chk("upd_t3_we_sel", {27'h0, t.we, t.sel}, 32'h1F);
        t = get_txn(4); chk("upd_t4_adr", t.adr, A_CTRL);
        chk("upd_t4_dat", t.dat, 32'h0000_0033);
        chk("upd_t4_we_sel", {27'h0, t.we, t.sel}, 32'h1F);

        // ack latency 5: signals held, spacing grows
        quiesce();
        lat = 5;
        wait_rises(3, 200, "lat5_rises_to");
        chk("lat5_space", 32'(spacing(1)), 32'd22);
        chk("lat5_hold_len", 32'(last_hi), 32'd5);
        chk("lat5_stable", 32'(stab_bad), 32'd0);

        // err on BOTINFO read
        quiesce();
        lat = 1;
        err_en = 1'b1;
        err_adr = A_INFO;
        updt_val = 1'b1;
        wait_log(2, 100, "err_log_to");
        updt_val = 1'b0;
        wait_log(3, 100, "err_next_to");
        t = get_txn(1);
        chk("err_t1_adr", t.adr, A_INFO);
        chk("err_t1_err", 32'(t.err), 32'd1);
        t = get_txn(2);
        chk("err_next_adr", t.adr, A_UPDT);
        chk("err_next_we", 32'(t.we), 32'd0);
        chk("err_gap", 32'(spacing(1)), 32'd18);
        chk("err_bus_err", 32'(bus_err), 32'd1);
        chk("err_bot_info", bot_info, 32'h3C50_0A04);
        chk("err_no_iv", 32'(iv_cnt), 32'd0);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("clr_bus_err", 32'(bus_err), 32'd0);

        // clr_err in the same cycle as a new error
        quiesce();
        err_adr = A_UPDT;
        wait_cyc(1'b1, 100, "coll_cyc_to");
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        err_en = 1'b0;
        chk("coll_bus_err", 32'(bus_err), 32'd1);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        step();
        chk("coll_cleared", 32'(bus_err), 32'd0);

        // enable dropped during ACK1
        quiesce();
        updt_val = 1'b1;
        begin
            int k = 0;
            while (!(wb_cyc_o && wb_adr_o == A_INTACK && wb_dat_o == 32'h1) && k < 100) begin
                step(); k++;
            end
            chk("dis_ack1_seen", 32'(k < 100), 32'd1);
        end
        enable = 1'b0;
        updt_val = 1'b0;
        log_q.delete();
        rises.delete();
        repeat (60) step();
        chk("dis_txn_count", 32'(log_q.size()), 32'd3);
        t = get_txn(0); chk("dis_t0", {t.adr[7:0], t.dat[23:0]}, {8'h08, 24'h1});
        t = get_txn(1); chk("dis_t1", {t.adr[7:0], t.dat[23:0]}, {8'h08, 24'h0});
        t = get_txn(2); chk("dis_t2", {t.adr[7:0], t.dat[23:0]}, {8'h00, 24'h33});
        chk("dis_rises", 32'(rises.size()), 32'd3);
        chk("dis_busy", 32'(busy), 32'd0);
        chk("dis_cyc", 32'(wb_cyc_o), 32'd0);

        // slave never answers
        quiesce();
        never_ack = 1'b1;
        enable = 1'b1;
        wait_cyc(1'b1, 50, "hang_cyc_to");
`ifdef WB_POLLER_TIMEOUT_EN
        repeat (7) step();
        chk("tmo_cyc_held", 32'(wb_cyc_o), 32'd1);
        step();
        chk("tmo_cyc_drop", 32'(wb_cyc_o), 32'd0);
        chk("tmo_bus_err", 32'(bus_err), 32'd1);
        wait_cyc(1'b1, 100, "tmo_recyc_to");
`else
        begin
            int hi = 0;
            repeat (1000) begin step(); if (wb_cyc_o) hi++; end
            chk("hang_cyc_held", 32'(hi), 32'd1000);
        end
        chk("hang_bus_err", 32'(bus_err), 32'd0);
`endif

        // async reset mid-read
        #1;
        rstn = 1'b0;
        #1;
        chk("arst_cyc_stb_we", {wb_cyc_o, wb_stb_o, wb_we_o}, 32'd0);
        chk("arst_adr", wb_adr_o, 32'h0);
        chk("arst_dat_sel", {wb_dat_o[27:0], wb_sel_o}, 32'h0);
        chk("arst_flags", {bus_err, busy, info_valid}, 32'd0);
        chk("arst_bot_info", bot_info, 32'h0);
        never_ack = 1'b0;
        enable = 1'b0;
        step();
        rstn = 1'b1;
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
